// File: rtl/sram_like_resp_pkg.sv
// Shared types and helpers for the sram-like responder memory model.
package sram_like_resp_pkg;

    typedef enum logic [1:0] {
        SRAM_SIZE_B = 2'd0,
        SRAM_SIZE_H = 2'd1,
        SRAM_SIZE_W = 2'd2
    } sram_size_e;

    // Width of the per-entry latency countdown; must hold DATA_LAT-1.
    function automatic int lat_width(input int data_lat);
        return $clog2(data_lat) + 1;
    endfunction

endpackage

// File: rtl/sram_like_if.sv
// sram-like req/addr_ok/data_ok bus between an initiator and a responder.
interface sram_like_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall_inj;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata, stall_inj,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata, stall_inj,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_resp_fifo.sv
// In-order queue of accepted transactions, each with its own data_ok latency countdown.
module sram_like_resp_fifo
    import sram_like_resp_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DATA_LAT = 1,
    parameter int LW       = lat_width(DATA_LAT),
    parameter int PW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    input  logic          fill,
    input  logic [PW-1:0] fill_ptr,
    input  logic [31:0]   fill_data,
    output logic [PW:0]   cnt,
    output logic          head_due,
    output logic [31:0]   head_data,
    output logic [PW-1:0] head_ptr,
    output logic [PW-1:0] tail_ptr
);
    localparam logic [LW-1:0] LAT_INIT = LW'(DATA_LAT - 1);

    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW:0]   cnt_reg;
    logic          valid_w [DEPTH];
    logic [LW-1:0] lat_w   [DEPTH];
    logic [31:0]   data_w  [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      cnt_reg <= cnt_reg + 1'b1;
            else if (pop && !push) cnt_reg <= cnt_reg - 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PW-1:0] SLOT = PW'(gi);
            logic          valid_reg;
            logic [LW-1:0] lat_reg;
            logic [31:0]   data_reg;

            // A freshly pushed entry starts at DATA_LAT-1; all others count down to 0.
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    lat_reg   <= '0;
                end else if (push && wr_ptr_reg == SLOT) begin
                    valid_reg <= 1'b1;
                    lat_reg   <= LAT_INIT;
                end else begin
                    if (pop && rd_ptr_reg == SLOT) valid_reg <= 1'b0;
                    if (lat_reg != '0) lat_reg <= lat_reg - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (push && wr_ptr_reg == SLOT)      data_reg <= push_data;
                else if (fill && fill_ptr == SLOT)   data_reg <= fill_data;
            end

            assign valid_w[gi] = valid_reg;
            assign lat_w[gi]   = lat_reg;
            assign data_w[gi]  = data_reg;
        end
    endgenerate

    assign cnt       = cnt_reg;
    assign head_due  = valid_w[rd_ptr_reg] && (lat_w[rd_ptr_reg] == '0);
    assign head_data = data_w[rd_ptr_reg];
    assign head_ptr  = rd_ptr_reg;
    assign tail_ptr  = wr_ptr_reg;
endmodule

// File: rtl/sram_like_resp.sv
// sram-like responder: word RAM with addr_ok stall injection and in-order data_ok latency.
module sram_like_resp
    import sram_like_resp_pkg::*;
#(
    parameter int AW          = 14,
    parameter int DEPTH       = 4,
    parameter int ADDR_OK_DLY = 0,
    parameter int DATA_LAT    = 1
) (
    input  logic clk,
    input  logic reset,
    sram_like_if.slave bus
);
    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW:0]   FULL = (PW + 1)'(DEPTH);

    logic [PW:0]   cnt;
    logic          head_due;
    logic [31:0]   head_data;
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic          hold_ok;
    logic          addr_ok;
    logic          accept;
    logic          data_ok;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [31:0]   head_word;
    logic          fill_reg;
    logic [PW-1:0] fill_ptr_reg;

    sram_size_e    unused_size;
    logic          unused_addr;
    assign unused_size = sram_size_e'(bus.size);
    assign unused_addr = ^{bus.addr[31:AW+2], bus.addr[1:0]};

    assign idx     = bus.addr[AW+1:2];
    assign addr_ok = bus.req & ~bus.stall_inj & (cnt < FULL) & hold_ok & ~reset;
    assign accept  = bus.req & addr_ok;

    generate
        if (ADDR_OK_DLY == 0) begin : g_no_hold
            assign hold_ok = 1'b1;
        end else begin : g_hold
            localparam int            HW       = $clog2(ADDR_OK_DLY + 1);
            localparam logic [HW-1:0] HOLD_MAX = HW'(ADDR_OK_DLY);
            logic [HW-1:0] hold_reg;

            always_ff @(posedge clk) begin
                if (reset || accept || !bus.req) hold_reg <= '0;
                else if (hold_reg != HOLD_MAX)   hold_reg <= hold_reg + 1'b1;
            end
            assign hold_ok = (hold_reg == HOLD_MAX);
        end
    endgenerate

    // One byte-lane RAM per wstrb bit, each with a registered read port.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [2**AW];
            logic [7:0] lane_rd_reg;

            always_ff @(posedge clk) begin
                if (accept && bus.wr && bus.wstrb[gi]) lane_mem[idx] <= bus.wdata[8*gi +: 8];
                if (accept && !bus.wr)                 lane_rd_reg   <= lane_mem[idx];
            end
            assign rd_word[8*gi +: 8] = lane_rd_reg;
        end
    endgenerate

    // Read data lands one cycle after the push; patch it into its slot and bypass to the head.
    always_ff @(posedge clk) begin
        if (reset) fill_reg <= 1'b0;
        else       fill_reg <= accept & ~bus.wr;
        fill_ptr_reg <= tail_ptr;
    end

    sram_like_resp_fifo #(
        .DEPTH    (DEPTH),
        .DATA_LAT (DATA_LAT)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (32'h0),
        .pop       (data_ok),
        .fill      (fill_reg),
        .fill_ptr  (fill_ptr_reg),
        .fill_data (rd_word),
        .cnt       (cnt),
        .head_due  (head_due),
        .head_data (head_data),
        .head_ptr  (head_ptr),
        .tail_ptr  (tail_ptr)
    );

    assign head_word   = (fill_reg && head_ptr == fill_ptr_reg) ? rd_word : head_data;
    assign data_ok     = head_due & ~reset;
    assign bus.addr_ok = addr_ok;
    assign bus.data_ok = data_ok;
    assign bus.rdata   = data_ok ? head_word : 32'h0;
endmodule

// File: tb/tb_sram_like_resp.sv
// Three responder configurations driven by shared stimulus, each checked every cycle against a timestamp-queue model.
module tb_sram_like_resp;
    localparam int NI = 3;

    function automatic int dly_of(input int m);
        return (m == 2) ? 2 : 0;
    endfunction
    function automatic int lat_of(input int m);
        return (m == 1) ? 8 : 1;
    endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, wr = 1'b0, stall_inj = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;

    logic [NI-1:0] aok_w, dok_w;
    logic [31:0]   rd_w [NI];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            sram_like_if bus ();
            assign bus.req       = req;
            assign bus.wr        = wr;
            assign bus.size      = size;
            assign bus.wstrb     = wstrb;
            assign bus.addr      = addr;
            assign bus.wdata     = wdata;
            assign bus.stall_inj = stall_inj;
            assign aok_w[gi]     = bus.addr_ok;
            assign dok_w[gi]     = bus.data_ok;
            assign rd_w[gi]      = bus.rdata;

            sram_like_resp #(
                .AW(10), .DEPTH(4), .ADDR_OK_DLY(dly_of(gi)), .DATA_LAT(lat_of(gi))
            ) dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus.slave)
            );
        end
    endgenerate

    int          n_checks = 0;
    int          n_pass   = 0;
    longint      cyc      = 0;
    logic [31:0] mram [NI][16];
    int          mcnt [NI];
    int          mhold [NI];
    longint      mdue [NI][4];
    logic [31:0] mdat [NI][4];
    logic        exp_acc [NI], exp_pop [NI];
    logic        s_aok [NI], s_dok [NI];
    logic [31:0] s_rd [NI];
    int          dut_acc [NI], dut_dok [NI];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Model: a list of outstanding entries, each tagged with the cycle from which it may answer.
    task automatic model_update(input int m);
        logic [3:0] wi;
        if (reset) begin
            mcnt[m]  = 0;
            mhold[m] = 0;
        end else begin
            if (exp_pop[m]) begin
                for (int k = 0; k < 3; k++) begin
                    mdue[m][k] = mdue[m][k+1];
                    mdat[m][k] = mdat[m][k+1];
                end
                mcnt[m]--;
            end
            if (exp_acc[m]) begin
                wi = addr[5:2];
                if (wr) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) mram[m][wi][8*b +: 8] = wdata[8*b +: 8];
                    mdat[m][mcnt[m]] = 32'h0;
                end else begin
                    mdat[m][mcnt[m]] = mram[m][wi];
                end
                mdue[m][mcnt[m]] = cyc + lat_of(m);
                mcnt[m]++;
            end
            if (exp_acc[m] || !req)      mhold[m] = 0;
            else if (mhold[m] < dly_of(m)) mhold[m]++;
        end
    endtask

    task automatic step_cycle();
        logic [31:0] erd;
        @(negedge clk);
        for (int m = 0; m < NI; m++) begin
            exp_acc[m] = req && !stall_inj && mcnt[m] < 4 && mhold[m] >= dly_of(m) && !reset;
            exp_pop[m] = !reset && mcnt[m] > 0 && mdue[m][0] <= cyc;
            erd        = exp_pop[m] ? mdat[m][0] : 32'h0;
            s_aok[m] = aok_w[m];
            s_dok[m] = dok_w[m];
            s_rd[m]  = rd_w[m];
            check($sformatf("addr_ok[%0d]", m), 32'(s_aok[m]), 32'(exp_acc[m]));
            check($sformatf("data_ok[%0d]", m), 32'(s_dok[m]), 32'(exp_pop[m]));
            check($sformatf("rdata[%0d]", m), s_rd[m], erd);
            if (reset) begin
                dut_acc[m] = 0;
                dut_dok[m] = 0;
            end else begin
                if (s_aok[m] && req) dut_acc[m]++;
                if (s_dok[m])        dut_dok[m]++;
            end
        end
        @(posedge clk);
        for (int m = 0; m < NI; m++) model_update(m);
        cyc++;
        #1;
    endtask

    task automatic drain();
        int busy;
        req = 1'b0;
        busy = 1;
        for (int k = 0; k < 40 && busy != 0; k++) begin
            step_cycle();
            busy = mcnt[0] + mcnt[1] + mcnt[2];
        end
        check("drain", 32'(busy), 32'd0);
    endtask

    // One transaction aimed at instance m; req drops on m's accept, then waits for m's data_ok.
    task automatic xfer(input int m, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
        bit got;
        req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d; size = 2'd2; stall_inj = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            step_cycle();
            if (s_aok[m]) got = 1'b1;
        end
        req = 1'b0;
        check($sformatf("xfer[%0d].accept", m), 32'(got), 32'd1);
        got = 1'b0; rd = 32'h0; lat = 0;
        for (int k = 1; k < 50 && !got; k++) begin
            step_cycle();
            if (s_dok[m]) begin
                got = 1'b1;
                rd  = s_rd[m];
                lat = k;
            end
        end
        check($sformatf("xfer[%0d].data_ok", m), 32'(got), 32'd1);
        $display("xfer[%0d] %s addr=%h wstrb=%h wdata=%h rdata=%h lat=%0d",
                 m, w ? "WR" : "RD", a, s, d, rd, lat);
        drain();
    endtask

    initial begin
        logic [31:0] rd, r1, r2;
        int          lat, n_acc, first_dok, nd;
        int          acc_k [8];

        for (int m = 0; m < NI; m++) begin
            mcnt[m] = 0; mhold[m] = 0; dut_acc[m] = 0; dut_dok[m] = 0;
            for (int k = 0; k < 16; k++) mram[m][k] = 32'h0;
            for (int k = 0; k < 4; k++) begin mdue[m][k] = 0; mdat[m][k] = 32'h0; end
        end

        // Reset state
        reset = 1'b1;
        step_cycle(); step_cycle();
        reset = 1'b0;
        step_cycle();
        for (int m = 0; m < NI; m++) begin
            check($sformatf("reset.addr_ok[%0d]", m), 32'(s_aok[m]), 32'd0);
            check($sformatf("reset.data_ok[%0d]", m), 32'(s_dok[m]), 32'd0);
            check($sformatf("reset.rdata[%0d]", m), s_rd[m], 32'd0);
        end

        // Fill the 16 words every instance will use (aimed at the slow-accept instance so all see it)
        for (int i = 0; i < 16; i++) xfer(2, 1'b1, 32'(i * 4), 4'hF, $urandom, rd, lat);

        // Basic write / read-back with latency 1
        xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat);
        check("t1.write_rdata", rd, 32'h0);
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
        check("t1.read_rdata", rd, 32'hDEADBEEF);
        check("t1.read_lat", 32'(lat), 32'd1);

        // Byte-lane merge, sub-word address offset ignored
        xfer(0, 1'b1, 32'h20, 4'hF, 32'h11223344, rd, lat);
        xfer(0, 1'b1, 32'h21, 4'h2, 32'h0000AA00, rd, lat);
        check("t2.strb_write_rdata", rd, 32'h0);
        xfer(0, 1'b0, 32'h22, 4'h1, 32'h0, rd, lat);
        check("t2.merged_rdata", rd, 32'h1122AA44);
        xfer(0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, rd, lat);
        check("t2.nostrb_lat", 32'(lat), 32'd1);
        xfer(0, 1'b0, 32'hFFFF_F010, 4'hF, 32'h0, rd, lat);
        check("t2.nostrb_unchanged", rd, 32'hDEADBEEF);

        // Full boundary on the DATA_LAT=8 instance
        req = 1'b1; wr = 1'b0; addr = 32'h10; wstrb = 4'hF; stall_inj = 1'b0;
        n_acc = 0; first_dok = -1;
        for (int k = 0; k < 12; k++) begin
            step_cycle();
            if (s_aok[1] && n_acc < 8) begin acc_k[n_acc] = k; n_acc++; end
            if (s_dok[1] && first_dok < 0) first_dok = k;
        end
        check("t3.n_acc_ge5", 32'(n_acc >= 5), 32'd1);
        for (int k = 0; k < 4; k++) check($sformatf("t3.acc%0d", k), 32'(acc_k[k]), 32'(k));
        check("t3.first_dok", 32'(first_dok), 32'd8);
        check("t3.acc4", 32'(acc_k[4]), 32'd9);
        drain();

        // addr_ok hold delay with a stall in the would-be accept cycle
        req = 1'b1; wr = 1'b0; addr = 32'h10;
        for (int k = 0; k < 4; k++) begin
            stall_inj = (k == 2);
            step_cycle();
            check($sformatf("t4.addr_ok_k%0d", k), 32'(s_aok[2]), 32'(k == 3));
        end
        stall_inj = 1'b0;
        drain();

        // Reset with three reads outstanding on the slow instance
        req = 1'b1; wr = 1'b0; addr = 32'h10;
        step_cycle(); step_cycle(); step_cycle();
        req = 1'b0;
        step_cycle();
        reset = 1'b1;
        step_cycle();
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            step_cycle();
            if (s_dok[1]) nd++;
        end
        check("t5.no_dok_after_reset", 32'(nd), 32'd0);
        xfer(1, 1'b0, 32'h10, 4'hF, 32'h0, rd, lat);
        check("t5.read_after_reset", rd, 32'hDEADBEEF);
        check("t5.read_lat", 32'(lat), 32'd8);

        // Random traffic, including rare resets
        for (int i = 0; i < 10000; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            req       = (r2[9:8] != 2'b00);
            wr        = r2[10];
            wstrb     = r2[14:11];
            stall_inj = (r2[17:15] == 3'b000);
            size      = r2[7:6];
            addr      = {r1[31:12], 6'b0, r2[3:0], r2[5:4]};
            wdata     = $urandom;
            reset     = ($urandom_range(0, 1499) == 0);
            step_cycle();
        end
        reset = 1'b0;
        drain();
        for (int m = 0; m < NI; m++)
            check($sformatf("t6.dok_eq_acc[%0d]", m), 32'(dut_dok[m]), 32'(dut_acc[m]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
